// File: rtl/ahb_regif.sv
// AHB-Lite slave front-end for a bank of NREG word registers.
// Turns address/data-phase transfers into one-cycle write, clear and read
// strobes. Legal accesses complete with zero wait states. Illegal accesses
// get a two-cycle ERROR response.
module ahb_regif #(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hsel_i,
    input  logic [31:0]          haddr_i,
    input  logic [1:0]           htrans_i,
    input  logic                 hwrite_i,
    input  logic [2:0]           hsize_i,
    input  logic [DW-1:0]        hwdata_i,
    input  logic                 hready_i,
    output logic                 hreadyout_o,
    output logic                 hresp_o,
    output logic [DW-1:0]        hrdata_o,
    output logic [NREG-1:0]      reg_wen_o,
    output logic [NREG-1:0]      reg_clr_o,
    output logic [DW-1:0]        reg_wdata_o,
    output logic [NREG-1:0]      reg_ren_o,
    input  logic [NREG*DW-1:0]   reg_rdata_i
);

    typedef enum logic [1:0] {StOkay, StErr1, StErr2} st_e;

    st_e        st_q, st_d;
    logic       accept;
    logic       addr_legal;
    logic       dp_valid_q, dp_valid_d;
    logic       dp_write_q, dp_write_d;
    logic       dp_alias_q, dp_alias_d;
    logic       dp_legal_q, dp_legal_d;
    logic [5:0] dp_idx_q,   dp_idx_d;
    logic       dp_active;
    logic [DW-1:0] rd_or;

    // Address bits above the map and the SEQ/NONSEQ distinction are not needed.
    logic unused_bits;
    assign unused_bits = ^{haddr_i[31:9], htrans_i[0]};

    // Address-phase acceptance and legality of the transfer being offered.
    always_comb begin
        accept     = hsel_i & htrans_i[1] & hready_i;
        addr_legal = (hsize_i == 3'b010) &&
                     (haddr_i[1:0] == 2'b00) &&
                     ({1'b0, haddr_i[7:2]} < 7'(NREG)) &&
                     !(!hwrite_i && haddr_i[8]);
    end

    // Next data-phase state: capture on every ready cycle, hold while stalled.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_alias_d = dp_alias_q;
        dp_legal_d = dp_legal_q;
        dp_idx_d   = dp_idx_q;
        if (hready_i) begin
            dp_valid_d = accept;
            dp_write_d = hwrite_i;
            dp_alias_d = haddr_i[8];
            dp_legal_d = addr_legal;
            dp_idx_d   = haddr_i[7:2];
        end
    end

    // Response FSM: an illegal acceptance enters ERR1 for its own data phase.
    always_comb begin
        st_d = StOkay;
        case (st_q)
            StErr1:  st_d = StErr2;
            default: if (accept && !addr_legal) st_d = StErr1;
        endcase
    end

    // State registers; reset aborts any data phase in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= StOkay;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_alias_q <= 1'b0;
            dp_legal_q <= 1'b0;
            dp_idx_q   <= 6'd0;
        end else begin
            st_q       <= st_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_alias_q <= dp_alias_d;
            dp_legal_q <= dp_legal_d;
            dp_idx_q   <= dp_idx_d;
        end
    end

    // One-hot strobes for the legal access in its data phase.
    always_comb begin
        dp_active = dp_valid_q && dp_legal_q && (st_q == StOkay);
        reg_wen_o = '0;
        reg_clr_o = '0;
        reg_ren_o = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (dp_active && (dp_idx_q == 6'(k))) begin
                reg_wen_o[k] = dp_write_q && !dp_alias_q;
                reg_clr_o[k] = dp_write_q && dp_alias_q;
                reg_ren_o[k] = !dp_write_q;
            end
        end
    end

    // Read data: unselected registers drive zero, so OR-combine all slices.
    always_comb begin
        rd_or = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            rd_or = rd_or | reg_rdata_i[k*DW +: DW];
        end
        hrdata_o    = (dp_active && !dp_write_q) ? rd_or : '0;
        reg_wdata_o = hwdata_i;
        hreadyout_o = (st_q != StErr1);
        hresp_o     = (st_q != StOkay);
    end

endmodule

// File: tb/tb_ahb_regif.sv
// Self-checking bench for ahb_regif: randomized AHB traffic, expected
// per-cycle responses queued at issue time and checked by a monitor.
module tb_ahb_regif;

    localparam int unsigned NREG = 8;
    localparam int unsigned DW   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DW-1:0]     hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DW-1:0]     hrdata;
    logic [NREG-1:0]   reg_wen;
    logic [NREG-1:0]   reg_clr;
    logic [DW-1:0]     reg_wdata;
    logic [NREG-1:0]   reg_ren;
    logic [NREG*DW-1:0] reg_rdata;

    always #5 clk = ~clk;

    // Single slave on the bus: bus ready follows this slave's ready.
    assign hready = hreadyout;

    ahb_regif #(.NREG(NREG), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsel_i      (hsel),
        .haddr_i     (haddr),
        .htrans_i    (htrans),
        .hwrite_i    (hwrite),
        .hsize_i     (hsize),
        .hwdata_i    (hwdata),
        .hready_i    (hready),
        .hreadyout_o (hreadyout),
        .hresp_o     (hresp),
        .hrdata_o    (hrdata),
        .reg_wen_o   (reg_wen),
        .reg_clr_o   (reg_clr),
        .reg_wdata_o (reg_wdata),
        .reg_ren_o   (reg_ren),
        .reg_rdata_i (reg_rdata)
    );

    // Register bank attached to the strobes.
    logic [DW-1:0] bank [NREG];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) bank[k] <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (reg_wen[k]) bank[k] <= reg_wdata;
                else if (reg_clr[k]) bank[k] <= '0;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int k = 0; k < NREG; k++) begin
            if (reg_ren[k]) reg_rdata[k*DW +: DW] = bank[k];
        end
    end

    typedef struct {
        int            cyc;
        logic          rdy;
        logic          resp;
        logic [NREG-1:0] wen;
        logic [NREG-1:0] clr;
        logic [NREG-1:0] ren;
        logic [DW-1:0] rdata;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model [NREG];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    logic [DW-1:0] pend_wd;
    bit            mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare DUT outputs against the expectation for this cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.cyc != cyc || hreadyout !== e.rdy || hresp !== e.resp ||
                reg_wen !== e.wen || reg_clr !== e.clr || reg_ren !== e.ren ||
                hrdata !== e.rdata || (e.wen != '0 && reg_wdata !== e.wdata)) begin
                fails++;
                $display("FAIL cycle %0d (exp cycle %0d): rdy/resp %b%b want %b%b wen %h want %h clr %h want %h ren %h want %h rdata %h want %h wdata %h want %h",
                         cyc, e.cyc, hreadyout, hresp, e.rdy, e.resp, reg_wen, e.wen,
                         reg_clr, e.clr, reg_ren, e.ren, hrdata, e.rdata, reg_wdata, e.wdata);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Drive one address phase (plus the previous write data) and queue the
    // expected response of its data phase. Called one step after a rising edge.
    task automatic issue(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        logic acc;
        logic legal;
        int   idx;
        hsel   = sel;
        htrans = tr;
        hwrite = wr;
        haddr  = addr;
        hsize  = sz;
        hwdata = pend_wd;
        idx    = int'(addr[7:2]);
        acc    = sel && tr[1];
        legal  = (sz == 3'd2) && (addr[1:0] == 2'd0) && (idx < NREG) && (wr || !addr[8]);
        e.cyc = cyc + 1; e.rdy = 1'b1; e.resp = 1'b0;
        e.wen = '0; e.clr = '0; e.ren = '0; e.rdata = '0; e.wdata = wd;
        if (acc && !legal) begin
            e.rdy  = 1'b0;
            e.resp = 1'b1;
        end else if (acc) begin
            if (wr && !addr[8]) begin
                e.wen[idx] = 1'b1;
                model[idx] = wd;
            end else if (wr) begin
                e.clr[idx] = 1'b1;
                model[idx] = '0;
            end else begin
                e.ren[idx] = 1'b1;
                e.rdata    = model[idx];
            end
        end
        q.push_back(e);
        pend_wd = wd;
        @(posedge clk); #1;
        if (acc && !legal) begin
            // Bus is stalled here; a pending NONSEQ must not be taken.
            hsel   = 1'b1;
            htrans = 2'b10;
            hwrite = 1'($urandom);
            haddr  = $urandom & 32'h0000_00fc;
            hsize  = 3'd2;
            hwdata = pend_wd;
            e.cyc = cyc + 1; e.rdy = 1'b1; e.resp = 1'b1;
            e.wen = '0; e.clr = '0; e.ren = '0; e.rdata = '0;
            q.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] addr;
        int          idx;
        rst_n = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hwdata = '0; pend_wd = '0;
        for (int k = 0; k < NREG; k++) model[k] = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset hreadyout", 64'(hreadyout), 64'd1);
        chk("reset hresp", 64'(hresp), 64'd0);
        chk("reset hrdata", 64'(hrdata), 64'd0);
        chk("reset strobes", 64'({reg_wen, reg_clr, reg_ren}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed: write/read back, clear alias, illegal forms, ERR2 accept.
        issue(1'b1, 2'b10, 1'b1, 32'h004, 3'd2, 32'hA5A5_0001);
        issue(1'b1, 2'b10, 1'b0, 32'h004, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 1'b1, 32'h104, 3'd2, 32'hFFFF_FFFF);
        issue(1'b1, 2'b10, 1'b0, 32'h004, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h020, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h000, 3'd1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h006, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h100, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 1'b1, 32'h020, 3'd2, 32'h1111_1111);
        issue(1'b1, 2'b10, 1'b1, 32'h000, 3'd2, 32'h0000_BEEF);
        issue(1'b1, 2'b10, 1'b0, 32'h000, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 1'b1, 32'h003, 3'd2, 32'h2222_2222);
        issue(1'b1, 2'b00, 1'b1, 32'h008, 3'd2, 32'h3333_3333);
        issue(1'b1, 2'b00, 1'b1, 32'h008, 3'd2, 32'h4444_4444);
        issue(1'b0, 2'b11, 1'b1, 32'h008, 3'd2, 32'h5555_5555);
        issue(1'b1, 2'b01, 1'b1, 32'h01c, 3'd2, 32'h6666_6666);
        issue(1'b1, 2'b10, 1'b0, 32'h008, 3'd2, 32'h0);

        // Randomized traffic, mostly legal, with every illegal flavour mixed in.
        for (int n = 0; n < 400; n++) begin
            logic       sel;
            logic       al;
            logic [1:0] lo;
            logic [2:0] sz;
            sel = ($urandom_range(0, 9) != 0);
            idx = int'($urandom_range(0, NREG + 1));
            al  = ($urandom_range(0, 3) == 0);
            lo  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            sz  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            addr = ($urandom & 32'hFFFF_FE00) | (32'(al) << 8) | (32'(idx) << 2) | 32'(lo);
            issue(sel, 2'($urandom), 1'($urandom), addr, sz, $urandom);
        end

        repeat (2) issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        // Reset during a write data phase must kill the strobe at once.
        mon_en = 1'b0;
        q.delete();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h008; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h1234_5678; htrans = 2'b00;
        chk("wen before reset", 64'(reg_wen), 64'h04);
        rst_n = 1'b0;
        #1;
        chk("wen after reset", 64'(reg_wen), 64'h00);
        chk("strobes after reset", 64'({reg_clr, reg_ren}), 64'd0);
        chk("ready/resp after reset", 64'({hreadyout, hresp}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_regif.md
# ahb_regif

AHB-Lite slave front-end that drives a bank of `regnb` storage registers. It converts AHB-Lite address/data-phase transfers into one-cycle write-enable, clear and read-enable strobes and per-register write data, and returns the OR-combined read data. It sits between an interconnect slave port and up to 64 word registers, with zero wait states on legal accesses and a two-cycle ERROR response on illegal ones.

## Interface

Parameters:

- `NREG`, 8: number of registers, 1..64.
- `DW`, 32: register and bus data width; fixed at 32.

Ports:

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `hsel_i` in 1: slave select from the interconnect decoder.
- `haddr_i` in 32: address. Only `[8:0]` are used.
- `htrans_i` in 2: transfer type.
- `hwrite_i` in 1: 1 = write.
- `hsize_i` in 3: transfer size.
- `hwdata_i` in DW: write data, valid in the data phase.
- `hready_i` in 1: bus ready, the previous transfer is complete.
- `hreadyout_o` out 1: this slave's ready.
- `hresp_o` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata_o` out DW: read data.
- `reg_wen_o` out NREG: one-hot write strobe.
- `reg_clr_o` out NREG: one-hot clear strobe.
- `reg_wdata_o` out DW: write data, common to all registers.
- `reg_ren_o` out NREG: one-hot read enable.
- `reg_rdata_i` in NREG*DW: concatenated register read data. Register k occupies `[k*DW +: DW]`. Each slice is 0 when its read enable is low.

## Operation

Address-phase acceptance:

- A transfer is accepted when `hsel_i & htrans_i[1] & hready_i` is high at a clock edge.
- On acceptance, capture the write flag, the index (`haddr_i[7:2]`), the alias flag (`haddr_i[8]`) and legality into data-phase registers.
- IDLE/BUSY transfers, and cycles where `hsel_i` is low, capture "no access". Their data phase returns OKAY and generates no strobes.

Legality:

- `hsize_i` must be 3'b010.
- `haddr_i[1:0]` must be 0.
- The index must be < NREG.
- A read with the alias bit set is illegal.

Address map (offsets within the slave):

- 0x000 + 4k: read or write register k.
- 0x100 + 4k: write-only clear alias for register k. Write data is ignored.

Data phase, legal access:

- Write: `reg_wen_o[k]` = 1, or `reg_clr_o[k]` = 1 for the alias, for exactly one cycle. `reg_wdata_o` = `hwdata_i`, passed combinationally.
- Read: `reg_ren_o[k]` = 1 for exactly one cycle. `hrdata_o` = OR of all `reg_rdata_i` slices.
- `hreadyout_o` = 1 and `hresp_o` = 0.

Data phase, illegal access:

- No strobes are generated.
- A two-cycle ERROR response follows (see the state machine).

Outputs outside an active data phase:

- All strobes = 0.
- `hrdata_o` = 0.
- `reg_wdata_o` = `hwdata_i` (don't-care).

State machine, `st`:

- OKAY: the default state. `hreadyout_o` = 1, `hresp_o` = 0. An illegal transfer in its data phase moves to ERR1 at that data-phase cycle, without spending an OKAY cycle.
- ERR1: `hreadyout_o` = 0, `hresp_o` = 1. Always goes to ERR2 on the next cycle.
- ERR2: `hreadyout_o` = 1, `hresp_o` = 1. Goes to OKAY on the next cycle.

ERR2 boundary rules:

- `hready_i` is high during ERR2, so a new transfer may be accepted there.
- A transfer accepted in ERR2 takes its data phase in the following cycle and is handled normally.
- If the master cancels by driving IDLE in ERR2, nothing is captured.

## Timing

- Reset values: `hreadyout_o` = 1, `hresp_o` = 0, `hrdata_o` = 0, all strobes = 0, `st` = OKAY, captured data-phase state = "no access".
- Reset asserted mid-transfer aborts it immediately. No strobe may be emitted after `rst_n` falls.
- Legal accesses take zero wait states. Strobes appear in the cycle after address acceptance. The register updates at the end of that cycle.
- Back-to-back write k then read k: the read data phase returns the newly written value, because the write lands at the end of the write's data-phase cycle.
- Back-to-back accesses to any mix of registers proceed at one transfer per cycle.
- At most one bit of `reg_wen_o | reg_clr_o | reg_ren_o` is set in any cycle.

## Test plan

- Reset → `hreadyout_o` = 1, `hresp_o` = 0, `hrdata_o` = 0, no strobes.
- Write 0xA5A5_0001 to 0x004, then read 0x004 back-to-back → `reg_wen_o` = 8'h02 for 1 cycle, then read returns 0xA5A5_0001 with OKAY and zero wait.
- Write 0x104 after the above, then read 0x004 → `reg_clr_o` = 8'h02, `reg_wen_o` = 0, read returns 0.
- Each of: read 0x020 (index 8, with NREG = 8); `hsize_i` = 3'b001; address 0x006; read 0x100 → cycles `hreadyout_o`/`hresp_o` = 0/1, then 1/1, then OKAY, with no strobes.
- Illegal write followed by a legal write to 0x000 accepted in ERR2 → the legal write strobes `reg_wen_o[0]` in the cycle after ERR2.
- IDLE transfer with `hsel_i` = 1, and a SEQ transfer with `hsel_i` = 0 → OKAY, no strobes. `rst_n` pulsed low during a write data phase → `reg_wen_o` drops to 0 immediately.
